// File: rtl/wino_pkg.sv
// rtl/wino_pkg.sv - shared types and constants for the Winograd tile scheduler
//
// Contents:
//   CNT_W_DEF      default width of block and OD counters
//   PE_LAT         cycles from edge valid to result_valid in the PE array
//   SZ_6X6/SZ_4X4  size-type encodings (1x1 on 6x6 tiles, 3x3 on 4x4 tiles)
//   sched_state_t  scheduler FSM states
package wino_pkg;

    localparam int CNT_W_DEF = 8;
    localparam int PE_LAT    = 4;

    localparam logic SZ_6X6 = 1'b0;
    localparam logic SZ_4X4 = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/wino_tile_scheduler_if.sv
// rtl/wino_tile_scheduler_if.sv - job, buffer-read and PE-edge signals of the tile scheduler
//
// Signals:
//   job control   start_i, cfg_size_type_i, cfg_block_cnt_i, cfg_od_cnt_i
//   array side    stall_i, result_valid_i
//   buffer reads  data_rd_en_o/data_rd_addr_o, weight_rd_en_o/weight_rd_od_o
//   PE edge       data_valid_o/data_addr_o, weight_valid_o/weight_od_o
//   status        size_type_o, block_cnt_o, busy_o, done_o, err_o, result_cnt_o
// Modports:
//   master  the job issuer / array model driving the scheduler
//   slave   the scheduler itself
interface wino_tile_scheduler_if
    import wino_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);

    logic                 start_i;
    logic                 cfg_size_type_i;
    logic [CNT_W-1:0]     cfg_block_cnt_i;
    logic [CNT_W-1:0]     cfg_od_cnt_i;
    logic                 stall_i;
    logic                 result_valid_i;

    logic                 data_rd_en_o;
    logic [CNT_W-1:0]     data_rd_addr_o;
    logic                 weight_rd_en_o;
    logic [CNT_W-1:0]     weight_rd_od_o;
    logic                 data_valid_o;
    logic [CNT_W-1:0]     data_addr_o;
    logic                 weight_valid_o;
    logic [CNT_W-1:0]     weight_od_o;
    logic                 size_type_o;
    logic [CNT_W-1:0]     block_cnt_o;
    logic                 busy_o;
    logic                 done_o;
    logic                 err_o;
    logic [2*CNT_W-1:0]   result_cnt_o;

    modport master (
        output start_i, cfg_size_type_i, cfg_block_cnt_i, cfg_od_cnt_i,
        output stall_i, result_valid_i,
        input  data_rd_en_o, data_rd_addr_o, weight_rd_en_o, weight_rd_od_o,
        input  data_valid_o, data_addr_o, weight_valid_o, weight_od_o,
        input  size_type_o, block_cnt_o, busy_o, done_o, err_o, result_cnt_o
    );

    modport slave (
        input  start_i, cfg_size_type_i, cfg_block_cnt_i, cfg_od_cnt_i,
        input  stall_i, result_valid_i,
        output data_rd_en_o, data_rd_addr_o, weight_rd_en_o, weight_rd_od_o,
        output data_valid_o, data_addr_o, weight_valid_o, weight_od_o,
        output size_type_o, block_cnt_o, busy_o, done_o, err_o, result_cnt_o
    );

endinterface

// File: rtl/wino_iter_counter.sv
// rtl/wino_iter_counter.sv - nested block/OD iteration counter (block inner, OD outer)
//
// Ports:
//   clk, reset      clock, synchronous active-low reset
//   clr             return to (od=0, blk=0)
//   en              advance one point
//   blk_cnt, od_cnt extents of the iteration space (both nonzero while enabled)
//   blk, od         current point
//   last            current point is (od_cnt-1, blk_cnt-1)
module wino_iter_counter
    import wino_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] blk_cnt,
    input  logic [CNT_W-1:0] od_cnt,
    output logic [CNT_W-1:0] blk,
    output logic [CNT_W-1:0] od,
    output logic             last
);

    logic blk_last;
    logic od_last;

    assign blk_last = (blk == blk_cnt - CNT_W'(1));
    assign od_last  = (od == od_cnt - CNT_W'(1));
    assign last     = blk_last && od_last;

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            blk <= '0;
            od  <= '0;
        end else if (en) begin
            if (blk_last) begin
                blk <= '0;
                od  <= od_last ? '0 : od + CNT_W'(1);
            end else begin
                blk <= blk + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/wino_tile_scheduler.sv
// rtl/wino_tile_scheduler.sv - job-level sequencer for the Winograd PE array
//
// Ports:
//   clk    clock
//   reset  synchronous active-low reset
//   bus    wino_tile_scheduler_if.slave: job config/start, stall and result
//          pulses in; buffer read strobes, PE edge valids/indices and job
//          status out
// Parameters:
//   CNT_W          width of block and OD counters
//   DRAIN_TIMEOUT  idle DRAIN cycles without a result before err_o
module wino_tile_scheduler
    import wino_pkg::*;
#(
    parameter int CNT_W         = CNT_W_DEF,
    parameter int DRAIN_TIMEOUT = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    wino_tile_scheduler_if.slave  bus
);

    localparam int CW2    = 2 * CNT_W;
    localparam int IDLE_W = $clog2(DRAIN_TIMEOUT + 1);

    sched_state_t       state;
    logic               size_type_q;
    logic [CNT_W-1:0]   block_cnt_q;
    logic [CNT_W-1:0]   od_cnt_q;
    logic [CW2-1:0]     result_cnt_q;
    logic [IDLE_W-1:0]  idle_cnt;
    logic               err_q;
    logic               done_q;
    logic               busy_q;

    logic               edge_valid_q;
    logic [CNT_W-1:0]   edge_addr_q;
    logic [CNT_W-1:0]   edge_od_q;

    logic [CNT_W-1:0]   blk;
    logic [CNT_W-1:0]   od;
    logic               iter_last;

    logic               issue;
    logic               accept;
    logic               counting;
    logic               result_hit;
    logic [CW2-1:0]     result_cnt_nx;
    logic [CW2-1:0]     job_total;

    // A read goes out on every unstalled ISSUE cycle; stall acts immediately
    // so no read is wasted while the array is back-pressured.
    assign issue      = (state == ISSUE) && !bus.stall_i;
    assign accept     = (state == IDLE) && bus.start_i &&
                        (bus.cfg_block_cnt_i != '0) && (bus.cfg_od_cnt_i != '0);
    assign counting   = (state == ISSUE) || (state == DRAIN);
    assign result_hit = counting && bus.result_valid_i;

    // The drain exit compares against the count including this cycle's pulse,
    // so the job ends on the edge that samples its final result.
    assign result_cnt_nx = result_cnt_q + CW2'(result_hit);
    assign job_total     = CW2'(block_cnt_q) * CW2'(od_cnt_q);

    wino_iter_counter #(
        .CNT_W (CNT_W)
    ) u_iter (
        .clk     (clk),
        .reset   (reset),
        .clr     (accept),
        .en      (issue),
        .blk_cnt (block_cnt_q),
        .od_cnt  (od_cnt_q),
        .blk     (blk),
        .od      (od),
        .last    (iter_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state        <= IDLE;
            size_type_q  <= SZ_6X6;
            block_cnt_q  <= '0;
            od_cnt_q     <= '0;
            result_cnt_q <= '0;
            idle_cnt     <= '0;
            err_q        <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            edge_valid_q <= 1'b0;
            edge_addr_q  <= '0;
            edge_od_q    <= '0;
        end else begin
            done_q <= 1'b0;

            if (result_hit) begin
                result_cnt_q <= result_cnt_nx;
            end

            case (state)
                IDLE: begin
                    if (accept) begin
                        size_type_q  <= bus.cfg_size_type_i;
                        block_cnt_q  <= bus.cfg_block_cnt_i;
                        od_cnt_q     <= bus.cfg_od_cnt_i;
                        result_cnt_q <= '0;
                        err_q        <= 1'b0;
                        busy_q       <= 1'b1;
                        state        <= ISSUE;
                    end else if (bus.start_i) begin
                        // Empty job: finish immediately, leave status untouched.
                        done_q <= 1'b1;
                        state  <= DONE;
                    end
                end

                ISSUE: begin
                    idle_cnt <= '0;
                    if (issue && iter_last) begin
                        state <= DRAIN;
                    end
                end

                DRAIN: begin
                    if (result_cnt_nx == job_total) begin
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end else if (bus.result_valid_i) begin
                        idle_cnt <= '0;
                    end else if (idle_cnt == IDLE_W'(DRAIN_TIMEOUT - 1)) begin
                        err_q  <= 1'b1;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end else begin
                        idle_cnt <= idle_cnt + IDLE_W'(1);
                    end
                end

                DONE: begin
                    size_type_q <= SZ_6X6;
                    block_cnt_q <= '0;
                    od_cnt_q    <= '0;
                    state       <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase

            // Tile buffers answer one cycle after the read; the edge stage
            // carries the indices alongside so valid and data line up.
            edge_valid_q <= issue;
            edge_addr_q  <= issue ? blk : '0;
            edge_od_q    <= issue ? od  : '0;
        end
    end

    assign bus.data_rd_en_o   = issue;
    assign bus.data_rd_addr_o = issue ? blk : '0;
    assign bus.weight_rd_en_o = issue;
    assign bus.weight_rd_od_o = issue ? od : '0;

    assign bus.data_valid_o   = edge_valid_q;
    assign bus.data_addr_o    = edge_addr_q;
    assign bus.weight_valid_o = edge_valid_q;
    assign bus.weight_od_o    = edge_od_q;

    assign bus.size_type_o    = size_type_q;
    assign bus.block_cnt_o    = block_cnt_q;
    assign bus.busy_o         = busy_q;
    assign bus.done_o         = done_q;
    assign bus.err_o          = err_q;
    assign bus.result_cnt_o   = result_cnt_q;

endmodule

// File: tb/tb_wino_tile_scheduler.sv
// tb/tb_wino_tile_scheduler.sv - scoreboard bench for wino_tile_scheduler
module tb_wino_tile_scheduler;
    import wino_pkg::*;

    localparam int CW  = 8;
    localparam int DTO = 64;

    typedef struct packed {
        logic [CW-1:0] b;
        logic [CW-1:0] o;
    } pt_t;

    typedef struct {
        bit chk_cnt;
        int cnt;
        bit err;
        int blk;
        bit sz;
        bit timeout;
    } job_t;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;

    int errors = 0;
    int checks = 0;

    pt_t  rd_q[$];
    pt_t  edge_q[$];
    job_t job_q[$];
    int   due_q[$];
    int   rd_cyc[$];

    int   rd_seen = 0;
    int   done_cnt = 0;
    int   last_rd_cyc = 0;
    bit   withhold = 1'b0;
    bit   model_err = 1'b0;
    bit   rand_stall = 1'b0;
    int   stall_force = 0;
    bit   prev_rd = 1'b0;
    bit   prev_done = 1'b0;

    wino_tile_scheduler_if #(.CNT_W(CW)) bus ();

    wino_tile_scheduler #(
        .CNT_W         (CW),
        .DRAIN_TIMEOUT (DTO)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Stall source: a directed burst takes priority over random back-pressure.
    initial begin
        bus.stall_i = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_force > 0) begin
                bus.stall_i = 1'b1;
                stall_force--;
            end else if (rand_stall) begin
                bus.stall_i = ($urandom_range(0, 3) == 0);
            end else begin
                bus.stall_i = 1'b0;
            end
        end
    end

    // Monitor and PE-array model.
    initial begin
        pt_t  p;
        job_t j;
        bit   rv;
        bus.result_valid_i = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                due_q.delete();
                bus.result_valid_i = 1'b0;
                prev_rd = 1'b0;
                prev_done = 1'b0;
            end else begin
                if (bus.stall_i && bus.busy_o)
                    check("rd_en_during_stall", bus.data_rd_en_o, 0);
                check("rd_en_pair", bus.weight_rd_en_o, bus.data_rd_en_o);
                check("valid_pair", bus.weight_valid_o, bus.data_valid_o);
                check("valid_follows_read", bus.data_valid_o, prev_rd);

                if (bus.data_rd_en_o) begin
                    check("read_expected", rd_q.size() > 0, 1);
                    if (rd_q.size() > 0) begin
                        p = rd_q.pop_front();
                        check("rd_addr", bus.data_rd_addr_o, p.b);
                        check("rd_od", bus.weight_rd_od_o, p.o);
                    end
                    rd_seen++;
                    rd_cyc.push_back(cyc);
                    last_rd_cyc = cyc;
                end

                if (bus.data_valid_o) begin
                    check("edge_expected", edge_q.size() > 0, 1);
                    if (edge_q.size() > 0) begin
                        p = edge_q.pop_front();
                        check("edge_addr", bus.data_addr_o, p.b);
                        check("edge_od", bus.weight_od_o, p.o);
                    end
                end else begin
                    check("edge_idle_zero", {bus.data_addr_o, bus.weight_od_o}, 0);
                end

                if (bus.done_o) begin
                    check("done_single_cycle", prev_done, 0);
                    check("done_expected", job_q.size() > 0, 1);
                    if (job_q.size() > 0) begin
                        j = job_q.pop_front();
                        check("done_err", bus.err_o, j.err);
                        check("done_block_cnt", bus.block_cnt_o, j.blk);
                        check("done_size_type", bus.size_type_o, j.sz);
                        check("done_busy_low", bus.busy_o, 0);
                        check("done_all_issued", rd_q.size(), 0);
                        if (j.chk_cnt)
                            check("done_result_cnt", bus.result_cnt_o, j.cnt);
                        if (j.timeout)
                            check("timeout_latency", cyc - last_rd_cyc, DTO + 1);
                    end
                    done_cnt++;
                end

                prev_rd = bus.data_rd_en_o;
                prev_done = bus.done_o;

                rv = 1'b0;
                if (due_q.size() > 0 && due_q[0] == cyc) begin
                    rv = 1'b1;
                    void'(due_q.pop_front());
                end
                if (bus.data_valid_o && !withhold)
                    due_q.push_back(cyc + PE_LAT);
                bus.result_valid_i = rv;
            end
        end
    end

    // Reference model: the expected read order is the plain nested loop,
    // OD outer and block inner; an empty job produces nothing.
    task automatic model_job(input int b, input int o, input bit sz);
        job_t j;
        pt_t  p;
        if (b != 0 && o != 0) begin
            for (int oo = 0; oo < o; oo++) begin
                for (int bb = 0; bb < b; bb++) begin
                    p.b = CW'(bb);
                    p.o = CW'(oo);
                    rd_q.push_back(p);
                    edge_q.push_back(p);
                end
            end
            j.chk_cnt = 1'b1;
            j.cnt = withhold ? 0 : b * o;
            j.err = withhold;
            j.blk = b;
            j.sz = sz;
            j.timeout = withhold;
            model_err = withhold;
        end else begin
            j.chk_cnt = 1'b0;
            j.cnt = 0;
            j.err = model_err;
            j.blk = 0;
            j.sz = 1'b0;
            j.timeout = 1'b0;
        end
        job_q.push_back(j);
    endtask

    task automatic pulse_start(input int b, input int o, input bit sz);
        @(negedge clk);
        #1;
        bus.cfg_block_cnt_i = CW'(b);
        bus.cfg_od_cnt_i = CW'(o);
        bus.cfg_size_type_i = sz;
        bus.start_i = 1'b1;
        @(posedge clk);
        #1;
        bus.start_i = 1'b0;
    endtask

    task automatic run_start(input int b, input int o, input bit sz);
        rd_seen = 0;
        rd_cyc.delete();
        model_job(b, o, sz);
        pulse_start(b, o, sz);
    endtask

    task automatic wait_done(input int budget);
        int base;
        int n;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check("done_within_budget", done_cnt > base, 1);
        @(negedge clk);
        #1;
        check("idle_busy", bus.busy_o, 0);
        check("idle_block_cnt", bus.block_cnt_o, 0);
        check("idle_size_type", bus.size_type_o, 0);
        check("idle_done", bus.done_o, 0);
    endtask

    initial begin
        int n;
        int base;
        int busy_hits;
        bit sz;
        int b;
        int o;

        bus.start_i = 1'b0;
        bus.cfg_size_type_i = 1'b0;
        bus.cfg_block_cnt_i = '0;
        bus.cfg_od_cnt_i = '0;

        repeat (3) @(posedge clk);
        #1;
        check("reset_rd_en", bus.data_rd_en_o, 0);
        check("reset_valid", bus.data_valid_o, 0);
        check("reset_busy", bus.busy_o, 0);
        check("reset_done", bus.done_o, 0);
        check("reset_err", bus.err_o, 0);
        check("reset_result_cnt", bus.result_cnt_o, 0);
        check("reset_block_cnt", bus.block_cnt_o, 0);
        @(negedge clk);
        reset = 1'b1;

        // Basic job with latency and latched-config checks.
        run_start(2, 3, SZ_4X4);
        @(negedge clk);
        #1;
        check("first_rd_en", bus.data_rd_en_o, 1);
        check("first_valid_not_yet", bus.data_valid_o, 0);
        check("busy_after_start", bus.busy_o, 1);
        check("latched_block_cnt", bus.block_cnt_o, 2);
        check("latched_size_type", bus.size_type_o, SZ_4X4);
        check("result_cnt_cleared", bus.result_cnt_o, 0);
        @(negedge clk);
        #1;
        check("first_valid_latency", bus.data_valid_o, 1);
        wait_done(200);

        // Directed 3-cycle stall after the second issue.
        run_start(2, 3, SZ_6X6);
        n = 0;
        while (rd_seen < 2 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        stall_force = 3;
        wait_done(200);
        check("stall_issue_total", rd_cyc.size(), 6);
        if (rd_cyc.size() >= 3)
            check("stall_gap", rd_cyc[2] - rd_cyc[1], 4);

        // Drain timeout with results withheld.
        withhold = 1'b1;
        run_start(1, 1, SZ_6X6);
        wait_done(300);
        withhold = 1'b0;
        check("err_sticky", bus.err_o, 1);

        // Empty job: no reads, no busy, err unchanged.
        base = done_cnt;
        busy_hits = 0;
        run_start(3, 0, SZ_4X4);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            if (bus.busy_o) busy_hits++;
        end
        check("empty_job_busy", busy_hits, 0);
        check("empty_job_done", done_cnt - base, 1);
        check("empty_job_err_kept", bus.err_o, 1);

        // Next accepted start clears err.
        run_start(1, 2, SZ_6X6);
        check("err_cleared_by_start", bus.err_o, 0);
        wait_done(200);

        // Reset in the middle of ISSUE, then a fresh job.
        run_start(2, 3, SZ_4X4);
        n = 0;
        while (rd_seen < 3 && n < 50) begin
            @(negedge clk);
            #2;
            n++;
        end
        reset = 1'b0;
        @(negedge clk);
        #1;
        check("midreset_rd_en", bus.data_rd_en_o, 0);
        check("midreset_valid", bus.data_valid_o, 0);
        check("midreset_busy", bus.busy_o, 0);
        check("midreset_block_cnt", bus.block_cnt_o, 0);
        check("midreset_result_cnt", bus.result_cnt_o, 0);
        check("midreset_done", bus.done_o, 0);
        rd_q.delete();
        edge_q.delete();
        job_q.delete();
        model_err = 1'b0;
        reset = 1'b1;
        run_start(2, 3, SZ_4X4);
        wait_done(200);

        // start_i during DRAIN must be ignored.
        base = done_cnt;
        run_start(2, 3, SZ_6X6);
        n = 0;
        while (!(rd_q.size() == 0 && bus.busy_o) && n < 100) begin
            @(negedge clk);
            #1;
            n++;
        end
        pulse_start(4, 4, SZ_4X4);
        wait_done(200);
        repeat (10) @(negedge clk);
        check("drain_start_one_done", done_cnt - base, 1);

        // Randomised jobs under random back-pressure.
        rand_stall = 1'b1;
        for (int i = 0; i < 8; i++) begin
            b = $urandom_range(1, 5);
            o = $urandom_range(1, 4);
            sz = 1'($urandom_range(0, 1));
            run_start(b, o, sz);
            wait_done(500);
        end
        rand_stall = 1'b0;
        repeat (3) @(negedge clk);
        check("all_jobs_retired", job_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
